// File: rtl/multicycle_control_fsm.sv
// Main control FSM for the multicycle MIPS datapath.
// Sequences fetch/decode/execute/memory/writeback per opcode, with a bounded
// wait on the memory ready handshake.
// Optional feature macro: MCU_JUMP_EN (adds the J/JAL JUMP state).
module multicycle_control_fsm #(
   parameter int unsigned MEM_WAIT_MAX = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] Opcode,
   input  logic       mem_ready,
   output logic       PCWrite,
   output logic       BranchEQ,
   output logic       BranchNE,
   output logic       IorD,
   output logic       MemRead,
   output logic       MemWrite,
   output logic       IRWrite,
   output logic [1:0] RegDst,
   output logic [1:0] MemtoReg,
   output logic       RegWrite,
   output logic       ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [1:0] PCSource,
   output logic [3:0] ALUOp,
   output logic       illegal_op,
   output logic       mem_timeout,
   output logic [3:0] state_o
);

   localparam int unsigned CW = 8;

   localparam logic [5:0] OP_R    = 6'b000000;
   localparam logic [5:0] OP_J    = 6'b000010;
   localparam logic [5:0] OP_JAL  = 6'b000011;
   localparam logic [5:0] OP_BEQ  = 6'b000100;
   localparam logic [5:0] OP_BNE  = 6'b000101;
   localparam logic [5:0] OP_ADDI = 6'b001000;
   localparam logic [5:0] OP_ORI  = 6'b001101;
   localparam logic [5:0] OP_LUI  = 6'b001111;
   localparam logic [5:0] OP_LW   = 6'b100011;
   localparam logic [5:0] OP_SW   = 6'b101011;

   typedef enum logic [3:0] {
      IDLE      = 4'd0,
      FETCH     = 4'd1,
      DECODE    = 4'd2,
      R_EXEC    = 4'd3,
      R_WB      = 4'd4,
      I_EXEC    = 4'd5,
      I_WB      = 4'd6,
      MEM_ADDR  = 4'd7,
      MEM_READ  = 4'd8,
      MEM_WRITE = 4'd9,
      LW_WB     = 4'd10,
      BRANCH    = 4'd11,
      JUMP      = 4'd12
   } state_t;

   typedef struct packed {
      logic       pc_write;
      logic       beq;
      logic       bne;
      logic       iord;
      logic       mem_read;
      logic       mem_write;
      logic [1:0] reg_dst;
      logic [1:0] mem_to_reg;
      logic       reg_write;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] pc_source;
      logic [3:0] alu_op;
   } ctl_t;

   state_t        state, nxt;
   logic [CW-1:0] wait_cnt;
   ctl_t          ctl;
   logic          wait_st, tmo, bad;

   // Moore strobes for a given state; opcode refines ALUOp/branch/JAL fields
   function automatic ctl_t moore(input state_t st, input logic [5:0] op);
      ctl_t c;
      c = '0;
      case (st)
         FETCH:     begin c.mem_read = 1'b1; c.alu_src_b = 2'd1; c.alu_op = 4'b0100; end
         DECODE:    begin c.alu_src_b = 2'd3; c.alu_op = 4'b0100; end
         R_EXEC:    begin c.alu_src_a = 1'b1; c.alu_op = 4'b1111; end
         R_WB:      begin c.reg_dst = 2'd1; c.reg_write = 1'b1; end
         I_EXEC: begin
            c.alu_src_a = 1'b1;
            c.alu_src_b = 2'd2;
            c.alu_op    = (op == OP_ORI) ? 4'b0101 : (op == OP_LUI) ? 4'b0110 : 4'b0100;
         end
         I_WB:      c.reg_write = 1'b1;
         MEM_ADDR: begin
            c.alu_src_a = 1'b1;
            c.alu_src_b = 2'd2;
            c.alu_op    = (op == OP_SW) ? 4'b0010 : 4'b0001;
         end
         MEM_READ:  begin c.iord = 1'b1; c.mem_read = 1'b1; end
         MEM_WRITE: begin c.iord = 1'b1; c.mem_write = 1'b1; end
         LW_WB:     begin c.mem_to_reg = 2'd1; c.reg_write = 1'b1; end
         BRANCH: begin
            c.alu_src_a = 1'b1;
            c.alu_op    = 4'b0011;
            c.pc_source = 2'd1;
            c.beq       = (op == OP_BEQ);
            c.bne       = (op == OP_BNE);
         end
`ifdef MCU_JUMP_EN
         JUMP: begin
            c.pc_write  = 1'b1;
            c.pc_source = 2'd2;
            if (op == OP_JAL) begin
               c.reg_dst    = 2'd2;
               c.mem_to_reg = 2'd2;
               c.reg_write  = 1'b1;
            end
         end
`endif
         default:   c = '0;
      endcase
      return c;
   endfunction

   // Next state, wait-limit abort and illegal-opcode detection
   always_comb begin
      nxt     = state;
      bad     = 1'b0;
      wait_st = (state == FETCH) || (state == MEM_READ) || (state == MEM_WRITE);
      tmo     = wait_st && !mem_ready && (wait_cnt == CW'(MEM_WAIT_MAX - 1));
      case (state)
         IDLE:      nxt = FETCH;
         FETCH:     nxt = mem_ready ? DECODE : FETCH;
         DECODE: begin
            case (Opcode)
               OP_R:                    nxt = R_EXEC;
               OP_ADDI, OP_ORI, OP_LUI: nxt = I_EXEC;
               OP_LW, OP_SW:            nxt = MEM_ADDR;
               OP_BEQ, OP_BNE:          nxt = BRANCH;
`ifdef MCU_JUMP_EN
               OP_J, OP_JAL:            nxt = JUMP;
`endif
               default: begin
                  nxt = FETCH;
                  bad = 1'b1;
               end
            endcase
         end
         R_EXEC:    nxt = R_WB;
         I_EXEC:    nxt = I_WB;
         MEM_ADDR:  nxt = (Opcode == OP_SW) ? MEM_WRITE : MEM_READ;
         MEM_READ: begin
            if (mem_ready)  nxt = LW_WB;
            else if (tmo)   nxt = FETCH;
         end
         MEM_WRITE: begin
            if (mem_ready || tmo) nxt = FETCH;
         end
         default:   nxt = FETCH;
      endcase
   end

   // State, wait counter and registered Moore strobes
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         wait_cnt <= '0;
         ctl      <= '0;
      end else begin
         state    <= nxt;
         wait_cnt <= (wait_st && !mem_ready && !tmo) ? wait_cnt + CW'(1) : '0;
         ctl      <= moore(nxt, Opcode);
      end
   end

   // The fetch-completion strobes must land in the same cycle as mem_ready
   assign IRWrite     = (state == FETCH) && mem_ready;
   assign PCWrite     = ctl.pc_write | IRWrite;
   assign BranchEQ    = ctl.beq;
   assign BranchNE    = ctl.bne;
   assign IorD        = ctl.iord;
   assign MemRead     = ctl.mem_read;
   assign MemWrite    = ctl.mem_write;
   assign RegDst      = ctl.reg_dst;
   assign MemtoReg    = ctl.mem_to_reg;
   assign RegWrite    = ctl.reg_write;
   assign ALUSrcA     = ctl.alu_src_a;
   assign ALUSrcB     = ctl.alu_src_b;
   assign PCSource    = ctl.pc_source;
   assign ALUOp       = ctl.alu_op;
   assign illegal_op  = bad;
   assign mem_timeout = tmo;
   assign state_o     = state;

endmodule
